muldiv_unit: RTL



---
 rtl/muldiv_unit_pkg.sv | 41 ++++
 rtl/muldiv_unit_if.sv | 29 ++
 rtl/muldiv_unit_sign_prep.sv | 38 +++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared constants and types for the RV32M multiply/divide unit.
//   - MD_* : funct3 encodings of the M-extension operations
//   - M_EXT : funct7 value that selects the M extension in decode
//   - ALU_* : ALU operation codes used by decode to route work to this unit
//   - md_state_t : control states of the iterative engine
//   - md_is_div : true for the four divide/remainder operations
package muldiv_unit_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [6:0] M_EXT = 7'b0000001;

  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } md_state_t;

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
//   Request/response bundle between the execute stage and the mul/div unit.
//   Request : in_valid, in_ready, in_op (funct3), in_a, in_b
//   Response: out_valid, out_ready, out_result
//   master = requester (execute stage), slave = muldiv_unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );

endinterface

// File: rtl/muldiv_unit_sign_prep.sv
// muldiv_sign_prep
//   Combinational operand conditioning for the mul/div engine.
//   Ports: op (funct3), a, b (raw operands) ->
//          mag_a, mag_b (magnitudes, raw value for unsigned operands),
//          neg_result (final result must be negated in FIXUP).
module muldiv_sign_prep
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  output logic             neg_result
);

  logic a_signed;
  logic b_signed;
  logic a_neg;
  logic b_neg;

  // MUL only keeps the low half, which is identical for signed and unsigned
  // operands, so it runs unsigned. MULHSU treats only rs1 as signed. A
  // remainder takes the sign of the dividend; everything else is negative
  // when exactly one operand is.
  always_comb begin
    a_signed   = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    b_signed   = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    a_neg      = a_signed && a[WIDTH-1];
    b_neg      = b_signed && b[WIDTH-1];
    mag_a      = a_neg ? (~a + 1'b1) : a;
    mag_b      = b_neg ? (~b + 1'b1) : b;
    neg_result = (op == MD_REM) ? a_neg : (a_neg ^ b_neg);
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit: one bit per cycle shift-add
//   multiply and restoring divide over WIDTH cycles, then a sign fixup cycle.
//   Ports: clk, rst (sync, active-high), flush (kills any in-flight op),
//          bus (muldiv_unit_if.slave: request in_*, response out_*).
//   Divide-by-zero and signed overflow are resolved at accept and answered
//   on the next cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_t        state;
  md_state_t        state_next;
  logic [CNT_W-1:0] counter;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] out_result_q;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             prep_neg;
  logic             accept;
  logic             special;
  logic [WIDTH-1:0] special_result;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   fix_result;

  muldiv_sign_prep #(.WIDTH(WIDTH)) u_sign_prep (
    .op         (bus.in_op),
    .a          (bus.in_a),
    .b          (bus.in_b),
    .mag_a      (mag_a),
    .mag_b      (mag_b),
    .neg_result (prep_neg)
  );

  // A request is taken only from IDLE and never in a flush cycle. Division by
  // zero and most-negative / -1 are answered directly without iterating.
  always_comb begin
    accept         = bus.in_valid && (state == IDLE) && !flush;
    special        = 1'b0;
    special_result = '0;
    if (md_is_div(bus.in_op) && (bus.in_b == '0)) begin
      special        = 1'b1;
      special_result = bus.in_op[1] ? bus.in_a : '1;
    end else if (((bus.in_op == MD_DIV) || (bus.in_op == MD_REM)) &&
                 (bus.in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.in_b == '1)) begin
      special        = 1'b1;
      special_result = bus.in_op[1] ? '0 : bus.in_a;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush beats everything, including a held result.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = special ? DONE : CALC;
        CALC:    if (counter == '0) state_next = FIXUP;
        FIXUP:   state_next = DONE;
        DONE:    if (bus.out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Handshake outputs are pure functions of the state.
  always_comb begin
    bus.in_ready   = (state == IDLE);
    bus.out_valid  = (state == DONE);
    bus.out_result = out_result_q;
  end

  // One iteration of the engine. Multiply keeps {hi,lo} as the running
  // product with the multiplier shifting out of lo. Divide shifts {hi,lo}
  // left, hi being the partial remainder and lo collecting quotient bits;
  // hi always stays below the divisor so the restored value fits in WIDTH.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mcand};
    div_ge    = !div_diff[WIDTH+1];
    if (md_is_div(op_q)) begin
      step_hi = div_ge ? WIDTH'(div_diff) : WIDTH'(div_shift);
      step_lo = {lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Sign fixup: the product is negated at full double width before the half
  // is picked; quotient and remainder are negated on their own.
  always_comb begin
    product = neg_q ? (~{hi, lo} + 1'b1) : {hi, lo};
    case (op_q)
      MD_MUL:                        fix_result = product[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  fix_result = product[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:               fix_result = neg_q ? (~lo + 1'b1) : lo;
      default:                       fix_result = neg_q ? (~hi + 1'b1) : hi;
    endcase
  end

  // Datapath registers. Operands are captured only at accept, so later
  // changes on the request bus have no effect on the running operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter      <= '0;
      op_q         <= MD_MUL;
      neg_q        <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      mcand        <= '0;
      out_result_q <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= bus.in_op;
            neg_q   <= prep_neg;
            hi      <= '0;
            lo      <= md_is_div(bus.in_op) ? mag_a : mag_b;
            mcand   <= md_is_div(bus.in_op) ? mag_b : mag_a;
            counter <= CNT_W'(WIDTH - 1);
            if (special) out_result_q <= special_result;
          end
        end
        CALC: begin
          hi <= step_hi;
          lo <= step_lo;
          if (counter != '0) counter <= counter - 1'b1;
        end
        FIXUP: out_result_q <= fix_result;
        default: ;
      endcase
    end
  end

endmodule
